// File: rtl/servo_pwm_decoder.sv
// Purpose: measures servo PWM high time and reports it in microseconds and as an 8-bit position.
// Latency: outputs update 3 clocks after the pwm_in falling edge is sampled.
// Backpressure: none; strobes are single-cycle and the consumer must sample them when they occur.
//
// Ports:
//   clock, reset   single clock, synchronous active-high reset
//   pwm_in         asynchronous servo PWM input, synchronised internally
//   pulse_us       last accepted high time in microseconds
//   position       last accepted position, 0 at MIN_US up to 250 at MAX_US
//   pulse_valid    one-cycle strobe when pulse_us/position update
//   range_err      one-cycle strobe when a pulse is rejected
//   signal_lost    level, high while no valid activity has been seen
module servo_pwm_decoder #(
    parameter int CYCLES_PER_US = 50,
    parameter int MIN_US        = 1000,
    parameter int MAX_US        = 2000,
    parameter int GLITCH_US     = 500,
    parameter int MAX_VALID_US  = 2500,
    parameter int LOSS_US       = 25000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [11:0] pulse_us,
    output logic [7:0]  position,
    output logic        pulse_valid,
    output logic        range_err,
    output logic        signal_lost
);

    localparam int PW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
    localparam int LW = $clog2(LOSS_US + 1);

    localparam logic [PW-1:0] PRE_LAST = PW'(CYCLES_PER_US - 1);
    localparam logic [11:0]   CNT_MAX  = 12'hFFF;
    localparam logic [11:0]   GLITCH_W = 12'(GLITCH_US);
    localparam logic [11:0]   MAXV_W   = 12'(MAX_VALID_US);
    localparam logic [11:0]   MIN_W    = 12'(MIN_US);
    localparam logic [11:0]   MAX_W    = 12'(MAX_US);
    localparam logic [LW-1:0] LOSS_W   = LW'(LOSS_US);
    localparam logic [LW-1:0] LOSS_HIT = LW'(LOSS_US - 1);

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        MEASURE,
        STUCK
    } state_t;

    state_t          state;
    logic            s1, s2, s3;
    logic            rise, fall;
    logic [PW-1:0]   prescale;
    logic            us_tick;
    logic [11:0]     us_cnt;
    logic [11:0]     us_now;
    logic [LW-1:0]   loss_cnt;
    logic [1:0]      warm;
    logic            in_range;
    logic            accept;
    logic [11:0]     clamped;
    logic [11:0]     span;

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    assign us_tick = (prescale == PRE_LAST);

    // Width including a tick landing in the current cycle, so that a pulse of
    // exactly k*CYCLES_PER_US cycles reports k on the falling-edge cycle.
    assign us_now = (us_tick && us_cnt != CNT_MAX) ? us_cnt + 12'd1 : us_cnt;

    assign in_range = (us_now >= GLITCH_W) && (us_now <= MAXV_W);
    assign accept   = (state == MEASURE) && fall && in_range;

    always_comb begin
        clamped = us_now;
        if (us_now < MIN_W) begin
            clamped = MIN_W;
        end else if (us_now > MAX_W) begin
            clamped = MAX_W;
        end
    end

    assign span = clamped - MIN_W;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            warm        <= 2'd0;
            prescale    <= '0;
            us_cnt      <= 12'd0;
            loss_cnt    <= '0;
            state       <= WAIT_LOW;
            pulse_us    <= 12'd0;
            position    <= 8'd0;
            pulse_valid <= 1'b0;
            range_err   <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;

            // The synchroniser resets to 0, which would look like a genuine low
            // right after reset; WAIT_LOW only trusts s2 once real samples
            // have propagated through both stages.
            if (warm != 2'd2) begin
                warm <= warm + 2'd1;
            end

            pulse_valid <= 1'b0;
            range_err   <= 1'b0;

            // Free-running microsecond prescaler, re-phased to every rising edge.
            if (rise || us_tick) begin
                prescale <= '0;
            end else begin
                prescale <= prescale + PW'(1);
            end

            // Time since the last rising edge, saturating at LOSS_US.
            if (rise) begin
                loss_cnt <= '0;
            end else if (us_tick && loss_cnt != LOSS_W) begin
                loss_cnt <= loss_cnt + LW'(1);
            end

            // A rise in the cycle the counter would hit LOSS_US wins.
            if (accept) begin
                signal_lost <= 1'b0;
            end else if (!rise && us_tick && loss_cnt == LOSS_HIT) begin
                signal_lost <= 1'b1;
            end

            if (rise) begin
                us_cnt <= 12'd0;
            end else if (state == MEASURE) begin
                us_cnt <= us_now;
            end

            case (state)
                WAIT_LOW: begin
                    if (warm == 2'd2 && !s2) begin
                        state <= WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (fall) begin
                        if (in_range) begin
                            pulse_us    <= us_now;
                            position    <= 8'(span >> 2);
                            pulse_valid <= 1'b1;
                        end else begin
                            range_err   <= 1'b1;
                        end
                        state <= WAIT_RISE;
                    end else if (us_now > MAXV_W) begin
                        // Over-long pulse: report once, then ignore until low.
                        range_err <= 1'b1;
                        state     <= STUCK;
                    end
                end
                STUCK: begin
                    if (!s2) begin
                        state <= WAIT_RISE;
                    end
                end
                default: state <= WAIT_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Purpose: self-checking bench for servo_pwm_decoder with a pulse-level reference model.
// Latency: checks are taken after generous settling windows, not at exact edges.
// Backpressure: not applicable; the bench drives pwm_in and watches strobes.
module tb_servo_pwm_decoder;

    localparam int CPU  = 2;
    localparam int MIN  = 1000;
    localparam int MAX  = 2000;
    localparam int GL   = 500;
    localparam int MV   = 2500;
    localparam int LOSS = 3000;

    logic        clock = 1'b0;
    logic        reset;
    logic        pwm_in;
    logic [11:0] pulse_us;
    logic [7:0]  position;
    logic        pulse_valid;
    logic        range_err;
    logic        signal_lost;

    int errors = 0;
    int checks = 0;

    // Strobe observations
    int pv_total = 0;
    int re_total = 0;
    int both_total = 0;
    int lost_at_strobe = 0;

    // Reference model state
    int          exp_pv = 0;
    int          exp_re = 0;
    logic [11:0] exp_us = 12'd0;
    logic [7:0]  exp_pos = 8'd0;
    logic        exp_lost = 1'b1;

    always #5 clock = ~clock;

    servo_pwm_decoder #(
        .CYCLES_PER_US(CPU),
        .MIN_US       (MIN),
        .MAX_US       (MAX),
        .GLITCH_US    (GL),
        .MAX_VALID_US (MV),
        .LOSS_US      (LOSS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .pulse_us   (pulse_us),
        .position   (position),
        .pulse_valid(pulse_valid),
        .range_err  (range_err),
        .signal_lost(signal_lost)
    );

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (pulse_valid === 1'b1) pv_total++;
            if (range_err === 1'b1) re_total++;
            if (pulse_valid === 1'b1 && range_err === 1'b1) both_total++;
            if (pulse_valid === 1'b1 && signal_lost !== 1'b0) lost_at_strobe++;
        end
    end

    function automatic int us(input int x);
        return x * CPU;
    endfunction

    function automatic logic [7:0] pos_of(input int w);
        int c;
        c = (w < MIN) ? MIN : ((w > MAX) ? MAX : w);
        return 8'((c - MIN) / 4);
    endfunction

    // Pulse-level model: h high cycles, gap cycles from rise to observation.
    function automatic void model_pulse(input int h, input int gap);
        int w;
        w = h / CPU;
        if (w > 4095) w = 4095;
        if (w >= GL && w <= MV) begin
            exp_pv++;
            exp_us   = 12'(w);
            exp_pos  = pos_of(w);
            exp_lost = 1'b0;
        end else begin
            exp_re++;
        end
        if (gap >= us(LOSS) + 8) exp_lost = 1'b1;
    endfunction

    task automatic run_pulse(input int h, input int low);
        @(posedge clock);
        #1 pwm_in = 1'b1;
        repeat (h) @(posedge clock);
        #1 pwm_in = 1'b0;
        repeat (low) @(posedge clock);
        #1;
        model_pulse(h, h + low);
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checks++; if (pulse_us !== 12'd0) begin errors++; $display("FAIL reset_pulse_us got %0d want 0", pulse_us); end
        checks++; if (position !== 8'd0) begin errors++; $display("FAIL reset_position got %0d want 0", position); end
        checks++; if (pulse_valid !== 1'b0) begin errors++; $display("FAIL reset_pulse_valid got %b want 0", pulse_valid); end
        checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL reset_range_err got %b want 0", range_err); end
        checks++; if (signal_lost !== 1'b1) begin errors++; $display("FAIL reset_signal_lost got %b want 1", signal_lost); end
        reset = 1'b0;
        repeat (10) @(posedge clock);
    endtask

    task automatic test_nominal;
        for (int i = 0; i < 3; i++) begin
            run_pulse(us(1500), us(200));
            checks++; if (pv_total !== exp_pv) begin errors++; $display("FAIL nominal_count[%0d] got %0d want %0d", i, pv_total, exp_pv); end
            checks++; if (pulse_us !== 12'd1500) begin errors++; $display("FAIL nominal_us[%0d] got %0d want 1500", i, pulse_us); end
            checks++; if (position !== 8'd125) begin errors++; $display("FAIL nominal_pos[%0d] got %0d want 125", i, position); end
            checks++; if (signal_lost !== 1'b0) begin errors++; $display("FAIL nominal_lost[%0d] got %b want 0", i, signal_lost); end
        end
    endtask

    task automatic test_endpoints;
        int widths[3] = '{1000, 2000, 2200};
        for (int i = 0; i < 3; i++) begin
            run_pulse(us(widths[i]), us(200));
            checks++; if (pv_total !== exp_pv) begin errors++; $display("FAIL endpoint_count[%0d] got %0d want %0d", i, pv_total, exp_pv); end
            checks++; if (pulse_us !== exp_us) begin errors++; $display("FAIL endpoint_us[%0d] got %0d want %0d", i, pulse_us, exp_us); end
            checks++; if (position !== exp_pos) begin errors++; $display("FAIL endpoint_pos[%0d] got %0d want %0d", i, position, exp_pos); end
        end
    endtask

    task automatic test_glitch;
        run_pulse(us(300), us(200));
        checks++; if (re_total !== exp_re) begin errors++; $display("FAIL glitch_err_count got %0d want %0d", re_total, exp_re); end
        checks++; if (pv_total !== exp_pv) begin errors++; $display("FAIL glitch_valid_count got %0d want %0d", pv_total, exp_pv); end
        checks++; if (pulse_us !== 12'd2200) begin errors++; $display("FAIL glitch_us_hold got %0d want 2200", pulse_us); end
        checks++; if (position !== 8'd250) begin errors++; $display("FAIL glitch_pos_hold got %0d want 250", position); end
    endtask

    task automatic test_stuck;
        int re0;
        re0 = re_total;
        @(posedge clock);
        #1 pwm_in = 1'b1;
        repeat (us(2501) - 6) @(posedge clock);
        #1;
        checks++; if (re_total !== re0) begin errors++; $display("FAIL stuck_early got %0d want %0d", re_total, re0); end
        repeat (12) @(posedge clock);
        #1;
        checks++; if (re_total !== re0 + 1) begin errors++; $display("FAIL stuck_at_2501 got %0d want %0d", re_total, re0 + 1); end
        repeat (us(4000) - us(2501) - 6) @(posedge clock);
        #1 pwm_in = 1'b0;
        repeat (us(200)) @(posedge clock);
        #1;
        exp_re++;
        exp_lost = 1'b1;
        checks++; if (re_total !== exp_re) begin errors++; $display("FAIL stuck_single got %0d want %0d", re_total, exp_re); end
        checks++; if (pv_total !== exp_pv) begin errors++; $display("FAIL stuck_no_valid got %0d want %0d", pv_total, exp_pv); end
        checks++; if (signal_lost !== exp_lost) begin errors++; $display("FAIL stuck_lost got %b want %b", signal_lost, exp_lost); end
        run_pulse(us(1200), us(200));
        checks++; if (pulse_us !== 12'd1200) begin errors++; $display("FAIL after_stuck_us got %0d want 1200", pulse_us); end
        checks++; if (position !== 8'd50) begin errors++; $display("FAIL after_stuck_pos got %0d want 50", position); end
        checks++; if (signal_lost !== 1'b0) begin errors++; $display("FAIL after_stuck_lost got %b want 0", signal_lost); end
    endtask

    task automatic test_loss;
        @(posedge clock);
        #1 pwm_in = 1'b1;
        repeat (us(1500)) @(posedge clock);
        #1 pwm_in = 1'b0;
        repeat (us(LOSS) - us(1500) - 6) @(posedge clock);
        #1;
        model_pulse(us(1500), 0);
        checks++; if (signal_lost !== 1'b0) begin errors++; $display("FAIL loss_before got %b want 0", signal_lost); end
        repeat (14) @(posedge clock);
        #1;
        exp_lost = 1'b1;
        checks++; if (signal_lost !== exp_lost) begin errors++; $display("FAIL loss_after got %b want %b", signal_lost, exp_lost); end
        run_pulse(us(1500), us(200));
        checks++; if (signal_lost !== 1'b0) begin errors++; $display("FAIL loss_cleared got %b want 0", signal_lost); end
        checks++; if (pv_total !== exp_pv) begin errors++; $display("FAIL loss_count got %0d want %0d", pv_total, exp_pv); end
    endtask

    task automatic test_reset_mid_pulse;
        @(posedge clock);
        #1 pwm_in = 1'b1;
        repeat (us(200)) @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        exp_us = 12'd0;
        exp_pos = 8'd0;
        exp_lost = 1'b1;
        checks++; if (pulse_us !== exp_us) begin errors++; $display("FAIL midreset_us got %0d want 0", pulse_us); end
        checks++; if (signal_lost !== exp_lost) begin errors++; $display("FAIL midreset_lost got %b want 1", signal_lost); end
        repeat (us(800)) @(posedge clock);
        #1 pwm_in = 1'b0;
        repeat (us(200)) @(posedge clock);
        #1;
        checks++; if (pv_total !== exp_pv) begin errors++; $display("FAIL midreset_no_valid got %0d want %0d", pv_total, exp_pv); end
        checks++; if (re_total !== exp_re) begin errors++; $display("FAIL midreset_no_err got %0d want %0d", re_total, exp_re); end
        checks++; if (position !== exp_pos) begin errors++; $display("FAIL midreset_pos got %0d want 0", position); end
        run_pulse(us(1100), us(200));
        checks++; if (pulse_us !== 12'd1100) begin errors++; $display("FAIL midreset_next_us got %0d want 1100", pulse_us); end
        checks++; if (position !== 8'd25) begin errors++; $display("FAIL midreset_next_pos got %0d want 25", position); end
        checks++; if (signal_lost !== 1'b0) begin errors++; $display("FAIL midreset_next_lost got %b want 0", signal_lost); end
    endtask

    task automatic test_boundaries;
        int hs[3];
        hs[0] = us(GL) - 1;
        hs[1] = us(GL);
        hs[2] = us(MV) + 1;
        for (int i = 0; i < 3; i++) begin
            run_pulse(hs[i], us(200));
            checks++; if (pv_total !== exp_pv) begin errors++; $display("FAIL bound_valid[%0d] got %0d want %0d", i, pv_total, exp_pv); end
            checks++; if (re_total !== exp_re) begin errors++; $display("FAIL bound_err[%0d] got %0d want %0d", i, re_total, exp_re); end
            checks++; if (pulse_us !== exp_us) begin errors++; $display("FAIL bound_us[%0d] got %0d want %0d", i, pulse_us, exp_us); end
            checks++; if (position !== exp_pos) begin errors++; $display("FAIL bound_pos[%0d] got %0d want %0d", i, position, exp_pos); end
        end
    endtask

    task automatic test_random;
        int h;
        int low;
        for (int i = 0; i < 4; i++) begin
            h   = int'($urandom_range(us(1800), us(300)));
            low = int'($urandom_range(us(250), us(150)));
            run_pulse(h, low);
            checks++; if (pv_total !== exp_pv) begin errors++; $display("FAIL rand_valid[%0d] h=%0d got %0d want %0d", i, h, pv_total, exp_pv); end
            checks++; if (re_total !== exp_re) begin errors++; $display("FAIL rand_err[%0d] h=%0d got %0d want %0d", i, h, re_total, exp_re); end
            checks++; if (pulse_us !== exp_us) begin errors++; $display("FAIL rand_us[%0d] h=%0d got %0d want %0d", i, h, pulse_us, exp_us); end
            checks++; if (position !== exp_pos) begin errors++; $display("FAIL rand_pos[%0d] h=%0d got %0d want %0d", i, h, position, exp_pos); end
            checks++; if (signal_lost !== exp_lost) begin errors++; $display("FAIL rand_lost[%0d] got %b want %b", i, signal_lost, exp_lost); end
        end
    endtask

    task automatic test_strobe_rules;
        checks++; if (both_total !== 0) begin errors++; $display("FAIL strobe_exclusive got %0d want 0", both_total); end
        checks++; if (lost_at_strobe !== 0) begin errors++; $display("FAIL lost_clear_at_strobe got %0d want 0", lost_at_strobe); end
    endtask

    initial begin
        reset  = 1'b1;
        pwm_in = 1'b0;
        test_reset();
        test_nominal();
        test_endpoints();
        test_glitch();
        test_stuck();
        test_loss();
        test_reset_mid_pulse();
        test_boundaries();
        test_random();
        test_strobe_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
